// File: rtl/sort_frame_unload.sv
// Ping-pong frame buffer behind the compare/sort network: captures whole sorted frames
// and streams them out word by word on a valid/ready interface, dropping frames when both slots are full.
module sort_frame_unload #(
    parameter int DATA_WIDTH     = 32,
    parameter int DATA_CNT       = 16,
    parameter     READ_ORDER     = "FWD",
    parameter int DROP_CNT_WIDTH = 16,
    localparam int IDX_W         = $clog2(DATA_CNT)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           compare_en,
    input  logic [DATA_WIDTH*DATA_CNT-1:0] compare_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic [IDX_W-1:0]               m_index,
    output logic                           m_last,
    output logic                           busy,
    output logic                           frame_drop,
    output logic [DROP_CNT_WIDTH-1:0]      drop_cnt
);

    localparam logic REV_ORDER_C = (READ_ORDER == "REV");

    // Buffer occupancy doubles as the control state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                         state_r;
    state_t                         state_nxt_s;
    logic                           rd_ptr_r;
    logic                           wr_ptr_r;
    logic [IDX_W-1:0]               cursor_r;
    logic [IDX_W-1:0]               index_s;
    logic [DATA_WIDTH*DATA_CNT-1:0] slot_r [2];
    logic                           valid_r;
    logic                           busy_r;
    logic                           drop_r;
    logic [DROP_CNT_WIDTH-1:0]      drop_cnt_r;
    logic                           beat_s;
    logic                           last_s;
    logic                           frame_end_s;
    logic                           accept_s;
    logic                           drop_s;

    assign beat_s      = valid_r & m_ready;
    assign last_s      = (cursor_r == IDX_W'(DATA_CNT - 1));
    assign frame_end_s = beat_s & last_s;
    assign drop_s      = compare_en & ~accept_s;

    // Next occupancy and capture decision; a full buffer frees a slot on the same edge as a frame end.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                accept_s = compare_en;
                if (compare_en) begin
                    state_nxt_s = ST_ONE;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                accept_s = compare_en;
                if (compare_en && !frame_end_s) begin
                    state_nxt_s = ST_FULL;
                end else if (!compare_en && frame_end_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_ONE;
                end
            end
            ST_FULL: begin
                accept_s = compare_en & frame_end_s;
                if (frame_end_s && !compare_en) begin
                    state_nxt_s = ST_ONE;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
                accept_s    = 1'b0;
            end
        endcase
    end

    // Map the beat cursor to a word position according to the read order.
    always_comb begin
        if (REV_ORDER_C) begin
            index_s = IDX_W'(DATA_CNT - 1) - cursor_r;
        end else begin
            index_s = cursor_r;
        end
    end

    // Control registers: occupancy, pointers, cursor and drop accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_EMPTY;
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            rd_ptr_r   <= 1'b0;
            wr_ptr_r   <= 1'b0;
            cursor_r   <= '0;
            drop_r     <= 1'b0;
            drop_cnt_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            valid_r <= (state_nxt_s != ST_EMPTY);
            busy_r  <= (state_nxt_s != ST_EMPTY);
            drop_r  <= drop_s;
            if (accept_s) begin
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (beat_s) begin
                if (last_s) begin
                    cursor_r <= '0;
                    rd_ptr_r <= ~rd_ptr_r;
                end else begin
                    cursor_r <= cursor_r + IDX_W'(1);
                end
            end
            if (drop_s && (drop_cnt_r != {DROP_CNT_WIDTH{1'b1}})) begin
                drop_cnt_r <= drop_cnt_r + DROP_CNT_WIDTH'(1);
            end
        end
    end

    // Frame storage is intentionally left unreset; occupancy guards against stale contents.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            slot_r[wr_ptr_r] <= compare_data;
        end
    end

    assign m_valid    = valid_r;
    assign busy       = busy_r;
    assign frame_drop = drop_r;
    assign drop_cnt   = drop_cnt_r;
    assign m_index    = index_s;
    assign m_last     = last_s;
    assign m_data     = slot_r[rd_ptr_r][index_s*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: tb/tb_sort_frame_unload.sv
// Randomised and directed checks of sort_frame_unload against a frame-queue reference model,
// with one FWD and one REV instance sharing stimulus.
module tb_sort_frame_unload;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int FW = W * N;
    localparam int IW = 2;
    localparam int CW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n_f, rst_n_r, compare_en, m_ready;
    logic [FW-1:0] compare_data;
    logic          f_valid, f_last, f_busy, f_drop, r_valid, r_last, r_busy, r_drop;
    logic [W-1:0]  f_data, r_data;
    logic [IW-1:0] f_index, r_index;
    logic [CW-1:0] f_cnt, r_cnt;

    sort_frame_unload #(.DATA_WIDTH(W), .DATA_CNT(N), .READ_ORDER("FWD"), .DROP_CNT_WIDTH(CW)) dut_fwd (
        .clk(clk), .rst_n(rst_n_f), .compare_en(compare_en), .compare_data(compare_data),
        .m_valid(f_valid), .m_ready(m_ready), .m_data(f_data), .m_index(f_index), .m_last(f_last),
        .busy(f_busy), .frame_drop(f_drop), .drop_cnt(f_cnt));

    sort_frame_unload #(.DATA_WIDTH(W), .DATA_CNT(N), .READ_ORDER("REV"), .DROP_CNT_WIDTH(CW)) dut_rev (
        .clk(clk), .rst_n(rst_n_r), .compare_en(compare_en), .compare_data(compare_data),
        .m_valid(r_valid), .m_ready(m_ready), .m_data(r_data), .m_index(r_index), .m_last(r_last),
        .busy(r_busy), .frame_drop(r_drop), .drop_cnt(r_cnt));

    // Observed outputs of whichever instance is under test.
    bit            sel;
    logic          o_valid, o_last, o_busy, o_drop;
    logic [W-1:0]  o_data;
    logic [IW-1:0] o_index;
    logic [CW-1:0] o_cnt;
    assign o_valid = sel ? r_valid : f_valid;
    assign o_last  = sel ? r_last  : f_last;
    assign o_busy  = sel ? r_busy  : f_busy;
    assign o_drop  = sel ? r_drop  : f_drop;
    assign o_data  = sel ? r_data  : f_data;
    assign o_index = sel ? r_index : f_index;
    assign o_cnt   = sel ? r_cnt   : f_cnt;

    // Reference model: queue of buffered frames and the beat position in the head frame.
    logic [FW-1:0] frames[$];
    int            pos;
    bit            mrev;
    logic          exp_drop;
    logic [CW-1:0] exp_cnt;
    int            n_vec = 0;
    int            n_err = 0;

    function automatic logic [FW-1:0] pack(input logic [W-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic exp_v();
        return frames.size() != 0;
    endfunction

    function automatic logic [W+IW:0] exp_beat();
        int idx = mrev ? (N - 1 - pos) : pos;
        logic [FW-1:0] f = frames[0];
        return {f[idx*W +: W], IW'(idx), (pos == N - 1)};
    endfunction

    task automatic model_reset();
        frames.delete();
        pos      = 0;
        exp_drop = 1'b0;
        exp_cnt  = '0;
    endtask

    task automatic step(input bit ce, input logic [FW-1:0] d, input bit rdy);
        bit beat, fe, acc;
        compare_en   = ce;
        compare_data = d;
        m_ready      = rdy;
        @(posedge clk);
        beat = (frames.size() != 0) && rdy;
        fe   = beat && (pos == N - 1);
        acc  = ce && ((frames.size() < 2) || fe);
        if (beat) begin
            if (fe) begin
                void'(frames.pop_front());
                pos = 0;
            end else begin
                pos++;
            end
        end
        exp_drop = ce && !acc;
        if (exp_drop && exp_cnt != 2'd3) exp_cnt++;
        if (acc) frames.push_back(d);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n_f = 1'b0; rst_n_r = 1'b0; sel = 1'b0; mrev = 1'b0;
        compare_en = 1'b1; compare_data = pack(16'd1, 16'd2, 16'd3, 16'd4); m_ready = 1'b1;
        #1;
        n_vec++;
        if ({f_valid, f_busy, f_drop, f_cnt, r_valid, r_busy, r_drop, r_cnt} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_values got %b want 0", {f_valid, f_busy, f_drop, f_cnt, r_valid, r_busy, r_drop, r_cnt});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({f_valid, f_busy, r_valid, r_busy} !== 4'd0) begin
            n_err++;
            $display("FAIL reset_ignores_strobe got %b want 0", {f_valid, f_busy, r_valid, r_busy});
        end
        compare_en = 1'b0;
        rst_n_f = 1'b1; rst_n_r = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        logic [FW-1:0] f = pack(16'd3, 16'd7, 16'd9, 16'd12);
        for (int c = 0; c < 7; c++) begin
            step(c == 0, f, 1'b1);
            n_vec++;
            if ({o_valid, o_busy, o_drop, o_cnt} !== {exp_v(), exp_v(), exp_drop, exp_cnt}) begin
                n_err++;
                $display("FAIL single_ctrl c=%0d got %b want %b", c, {o_valid, o_busy, o_drop, o_cnt}, {exp_v(), exp_v(), exp_drop, exp_cnt});
            end
            if (exp_v()) begin
                n_vec++;
                if ({o_data, o_index, o_last} !== exp_beat()) begin
                    n_err++;
                    $display("FAIL single_beat c=%0d got %h want %h", c, {o_data, o_index, o_last}, exp_beat());
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [FW-1:0] f = pack(16'd3, 16'd7, 16'd9, 16'd12);
        for (int c = 0; c < 16; c++) begin
            step(c == 0, f, (c % 3) == 0);
            n_vec++;
            if ({o_valid, o_busy, o_drop, o_cnt} !== {exp_v(), exp_v(), exp_drop, exp_cnt}) begin
                n_err++;
                $display("FAIL bp_ctrl c=%0d got %b want %b", c, {o_valid, o_busy, o_drop, o_cnt}, {exp_v(), exp_v(), exp_drop, exp_cnt});
            end
            if (exp_v()) begin
                n_vec++;
                if ({o_data, o_index, o_last} !== exp_beat()) begin
                    n_err++;
                    $display("FAIL bp_beat c=%0d got %h want %h", c, {o_data, o_index, o_last}, exp_beat());
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] a = pack(16'd1, 16'd2, 16'd3, 16'd4);
        logic [FW-1:0] b = pack(16'd5, 16'd6, 16'd7, 16'd8);
        for (int c = 0; c < 11; c++) begin
            step(c == 0 || c == 2, (c == 0) ? a : b, 1'b1);
            n_vec++;
            if ({o_valid, o_busy, o_drop, o_cnt} !== {exp_v(), exp_v(), exp_drop, exp_cnt}) begin
                n_err++;
                $display("FAIL b2b_ctrl c=%0d got %b want %b", c, {o_valid, o_busy, o_drop, o_cnt}, {exp_v(), exp_v(), exp_drop, exp_cnt});
            end
            if (exp_v()) begin
                n_vec++;
                if ({o_data, o_index, o_last} !== exp_beat()) begin
                    n_err++;
                    $display("FAIL b2b_beat c=%0d got %h want %h", c, {o_data, o_index, o_last}, exp_beat());
                end
            end
        end
    endtask

    task automatic test_drop();
        logic [FW-1:0] fr [3];
        fr[0] = pack(16'h11, 16'h12, 16'h13, 16'h14);
        fr[1] = pack(16'h21, 16'h22, 16'h23, 16'h24);
        fr[2] = pack(16'h31, 16'h32, 16'h33, 16'h34);
        for (int c = 0; c < 16; c++) begin
            step(c < 3, fr[(c < 3) ? c : 0], c >= 5);
            n_vec++;
            if ({o_valid, o_busy, o_drop, o_cnt} !== {exp_v(), exp_v(), exp_drop, exp_cnt}) begin
                n_err++;
                $display("FAIL drop_ctrl c=%0d got %b want %b", c, {o_valid, o_busy, o_drop, o_cnt}, {exp_v(), exp_v(), exp_drop, exp_cnt});
            end
            if (exp_v()) begin
                n_vec++;
                if ({o_data, o_index, o_last} !== exp_beat()) begin
                    n_err++;
                    $display("FAIL drop_beat c=%0d got %h want %h", c, {o_data, o_index, o_last}, exp_beat());
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [FW-1:0] fr [3];
        fr[0] = pack(16'hA0, 16'hA1, 16'hA2, 16'hA3);
        fr[1] = pack(16'hB0, 16'hB1, 16'hB2, 16'hB3);
        fr[2] = pack(16'hC0, 16'hC1, 16'hC2, 16'hC3);
        for (int c = 0; c < 18; c++) begin
            step(c == 0 || c == 1 || c == 6, fr[(c == 0) ? 0 : (c == 1) ? 1 : 2], c >= 3);
            n_vec++;
            if ({o_valid, o_busy, o_drop, o_cnt} !== {exp_v(), exp_v(), exp_drop, exp_cnt}) begin
                n_err++;
                $display("FAIL simul_ctrl c=%0d got %b want %b", c, {o_valid, o_busy, o_drop, o_cnt}, {exp_v(), exp_v(), exp_drop, exp_cnt});
            end
            if (exp_v()) begin
                n_vec++;
                if ({o_data, o_index, o_last} !== exp_beat()) begin
                    n_err++;
                    $display("FAIL simul_beat c=%0d got %h want %h", c, {o_data, o_index, o_last}, exp_beat());
                end
            end
        end
    endtask

    task automatic test_random();
        logic [FW-1:0] d;
        bit ce, rdy;
        for (int c = 0; c < 420; c++) begin
            d   = {$urandom, $urandom};
            ce  = (c < 400) && (($urandom % 3) == 0);
            rdy = (c >= 400) || (((c % 200) < 100) ? (($urandom % 4) == 0) : (($urandom % 4) != 0));
            step(ce, d, rdy);
            n_vec++;
            if ({o_valid, o_busy, o_drop, o_cnt} !== {exp_v(), exp_v(), exp_drop, exp_cnt}) begin
                n_err++;
                $display("FAIL rand_ctrl c=%0d got %b want %b", c, {o_valid, o_busy, o_drop, o_cnt}, {exp_v(), exp_v(), exp_drop, exp_cnt});
            end
            if (exp_v()) begin
                n_vec++;
                if ({o_data, o_index, o_last} !== exp_beat()) begin
                    n_err++;
                    $display("FAIL rand_beat c=%0d got %h want %h", c, {o_data, o_index, o_last}, exp_beat());
                end
            end
        end
    endtask

    task automatic test_rev_reset();
        logic [FW-1:0] fr [3];
        fr[0] = pack(16'd3, 16'd7, 16'd9, 16'd12);
        fr[1] = pack(16'h51, 16'h52, 16'h53, 16'h54);
        fr[2] = pack(16'h61, 16'h62, 16'h63, 16'h64);
        sel = 1'b1; mrev = 1'b1;
        rst_n_f = 1'b0; rst_n_r = 1'b0;
        @(negedge clk);
        rst_n_f = 1'b1; rst_n_r = 1'b1;
        model_reset();
        // Fill, drop one, drain A fully and two beats of B.
        for (int c = 0; c < 9; c++) begin
            step(c < 3, fr[(c < 3) ? c : 0], c >= 3);
            n_vec++;
            if ({o_valid, o_busy, o_drop, o_cnt} !== {exp_v(), exp_v(), exp_drop, exp_cnt}) begin
                n_err++;
                $display("FAIL rev_ctrl c=%0d got %b want %b", c, {o_valid, o_busy, o_drop, o_cnt}, {exp_v(), exp_v(), exp_drop, exp_cnt});
            end
            if (exp_v()) begin
                n_vec++;
                if ({o_data, o_index, o_last} !== exp_beat()) begin
                    n_err++;
                    $display("FAIL rev_beat c=%0d got %h want %h", c, {o_data, o_index, o_last}, exp_beat());
                end
            end
        end
        compare_en = 1'b0;
        rst_n_r = 1'b0;
        #1;
        n_vec++;
        if ({r_valid, r_busy, r_drop, r_cnt} !== 5'd0) begin
            n_err++;
            $display("FAIL rev_async_reset got %b want 0", {r_valid, r_busy, r_drop, r_cnt});
        end
        model_reset();
        @(negedge clk);
        rst_n_r = 1'b1;
        for (int c = 0; c < 7; c++) begin
            step(c == 0, fr[0], 1'b1);
            n_vec++;
            if ({o_valid, o_busy, o_drop, o_cnt} !== {exp_v(), exp_v(), exp_drop, exp_cnt}) begin
                n_err++;
                $display("FAIL rev_post_ctrl c=%0d got %b want %b", c, {o_valid, o_busy, o_drop, o_cnt}, {exp_v(), exp_v(), exp_drop, exp_cnt});
            end
            if (exp_v()) begin
                n_vec++;
                if ({o_data, o_index, o_last} !== exp_beat()) begin
                    n_err++;
                    $display("FAIL rev_post_beat c=%0d got %h want %h", c, {o_data, o_index, o_last}, exp_beat());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_single();
        test_backpressure();
        test_back_to_back();
        test_drop();
        test_simultaneous();
        test_random();
        test_rev_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
